// File: rtl/rf_arbiter.sv
// Two-requester arbiter in front of a 2-read/1-write register file: round-robin with lock, 1-cycle read return.
// Optional same-access write-to-read bypass is enabled by defining RF_WRITE_BYPASS_EN.
module rf_arbiter #(
    parameter int AW = 4,
    parameter int DW = 20
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          req0,
    input  logic          req1,
    input  logic          lock0,
    input  logic          lock1,
    input  logic          we0,
    input  logic          we1,
    input  logic [AW-1:0] ra0_0,
    input  logic [AW-1:0] ra1_0,
    input  logic [AW-1:0] ra0_1,
    input  logic [AW-1:0] ra1_1,
    input  logic [AW-1:0] wa0,
    input  logic [AW-1:0] wa1,
    input  logic [DW-1:0] wd0,
    input  logic [DW-1:0] wd1,
    output logic          gnt0,
    output logic          gnt1,
    output logic          rvalid0,
    output logic          rvalid1,
    output logic [DW-1:0] rd0_data,
    output logic [DW-1:0] rd1_data,
    output logic          rf_wr_en,
    output logic [AW-1:0] rf_wr_addr,
    output logic [AW-1:0] rf_rd0_addr,
    output logic [AW-1:0] rf_rd1_addr,
    output logic [DW-1:0] rf_wr_data,
    input  logic [DW-1:0] rf_rd0_data,
    input  logic [DW-1:0] rf_rd1_data
);

    typedef enum logic [1:0] {IDLE, LOCK0, LOCK1} state_t;

    state_t state, state_nxt;
    logic   last_gnt;          // index of the requester granted most recently
    logic   arb0, arb1;        // round-robin pick when no lock applies
    logic   pick0, pick1;

    assign arb0 = req0 & (~req1 | last_gnt);
    assign arb1 = req1 & (~req0 | ~last_gnt);

    // NOTE: every always_comb output gets a default first, so no path leaves a latch behind.
    always_comb begin
        pick0     = 1'b0;
        pick1     = 1'b0;
        state_nxt = IDLE;
        case (state)
            LOCK0: begin
                if (req0) pick0 = 1'b1;
                else      pick1 = arb1;
                state_nxt = (req0 & lock0) ? LOCK0 : IDLE;
            end
            LOCK1: begin
                if (req1) pick1 = 1'b1;
                else      pick0 = arb0;
                state_nxt = (req1 & lock1) ? LOCK1 : IDLE;
            end
            default: begin
                pick0 = arb0;
                pick1 = arb1;
                if (pick0 & lock0)      state_nxt = LOCK0;
                else if (pick1 & lock1) state_nxt = LOCK1;
                else                    state_nxt = IDLE;
            end
        endcase
    end

    // Grants are held off combinationally for the whole time reset is asserted.
    assign gnt0 = pick0 & rst_n;
    assign gnt1 = pick1 & rst_n;

    always_comb begin
        rf_wr_en    = 1'b0;
        rf_wr_addr  = '0;
        rf_wr_data  = '0;
        rf_rd0_addr = '0;
        rf_rd1_addr = '0;
        if (gnt0) begin
            rf_wr_en    = we0;
            rf_wr_addr  = wa0;
            rf_wr_data  = wd0;
            rf_rd0_addr = ra0_0;
            rf_rd1_addr = ra1_0;
        end else if (gnt1) begin
            rf_wr_en    = we1;
            rf_wr_addr  = wa1;
            rf_wr_data  = wd1;
            rf_rd0_addr = ra0_1;
            rf_rd1_addr = ra1_1;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            last_gnt <= 1'b1;
            rvalid0  <= 1'b0;
            rvalid1  <= 1'b0;
        end else begin
            state   <= state_nxt;
            rvalid0 <= gnt0;
            rvalid1 <= gnt1;
            if (gnt0 | gnt1) last_gnt <= gnt1;
        end
    end

`ifdef RF_WRITE_BYPASS_EN
    logic [AW-1:0] byp_addr;
    logic [DW-1:0] byp_data;
    logic          byp_hit0, byp_hit1;

    // Match flags are only set by a write; a non-writing access clears them.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            byp_addr <= '0;
            byp_data <= '0;
            byp_hit0 <= 1'b0;
            byp_hit1 <= 1'b0;
        end else begin
            byp_hit0 <= rf_wr_en && (rf_rd0_addr == rf_wr_addr);
            byp_hit1 <= rf_wr_en && (rf_rd1_addr == rf_wr_addr);
            if (rf_wr_en) begin
                byp_addr <= rf_wr_addr;
                byp_data <= rf_wr_data;
            end
        end
    end

    assign rd0_data = byp_hit0 ? byp_data : rf_rd0_data;
    assign rd1_data = byp_hit1 ? byp_data : rf_rd1_data;
`else
    assign rd0_data = rf_rd0_data;
    assign rd1_data = rf_rd1_data;
`endif

endmodule
